// File: rtl/r_pkg.sv
// r_pkg: shared constants and types for the r_fifo slice.
// Holds the size defaults, the packet header field layout and the stored entry format.
package r_pkg;

    localparam int DEPTH_DEF = 16;
    localparam int WIDTH_DEF = 8;

    // Header byte layout: [7:2] payload length, [1:0] destination address
    localparam int LEN_MSB = 7;
    localparam int LEN_LSB = 2;
    localparam int ADDR_W  = 2;

    // Packet counter holds length+1 (payload plus parity), one bit wider than the field
    localparam int CNT_W = LEN_MSB - LEN_LSB + 2;

    // One stored FIFO entry: header marker plus data byte
    typedef struct packed {
        logic                 lfd;
        logic [WIDTH_DEF-1:0] data;
    } entry_t;

    // Bytes still to come after a header: payload length plus the parity byte
    function automatic logic [CNT_W-1:0] pkt_len(input logic [LEN_MSB:0] hdr);
        return {1'b0, hdr[LEN_MSB:LEN_LSB]} + CNT_W'(1);
    endfunction

endpackage

// File: rtl/r_fifo_if.sv
// r_fifo_if: handshake and data bundle between the synchronizer/client side and r_fifo.
// The overrun output exists only when R_FIFO_OVERRUN_FLAG_EN is defined.
interface r_fifo_if #(
    parameter int WIDTH = r_pkg::WIDTH_DEF
);
    logic             soft_reset;
    logic             write_enb;
    logic             read_enb;
    logic             lfd_state;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
`ifdef R_FIFO_OVERRUN_FLAG_EN
    logic             overrun;

    modport master (
        output soft_reset, write_enb, read_enb, lfd_state, data_in,
        input  data_out, full, empty, overrun
    );
    modport slave (
        input  soft_reset, write_enb, read_enb, lfd_state, data_in,
        output data_out, full, empty, overrun
    );
`else
    modport master (
        output soft_reset, write_enb, read_enb, lfd_state, data_in,
        input  data_out, full, empty
    );
    modport slave (
        input  soft_reset, write_enb, read_enb, lfd_state, data_in,
        output data_out, full, empty
    );
`endif
endinterface

// File: rtl/r_fifo_mem.sv
// r_fifo_mem: DEPTH x EW storage with one synchronous write port and one read port.
// The read port is combinational; the parent registers the selected byte into data_out
// and needs the entry's header bit in the same cycle to update its packet counter.
module r_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int EW    = 9
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [EW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [EW-1:0]            rdata
);
    logic [EW-1:0] mem_reg [DEPTH];

    // Store the incoming entry on an accepted write
    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/r_fifo.sv
// r_fifo: router output FIFO with header-aware packet counter.
// Pointers carry a wrap bit above the address; data_out is registered and zeroed when
// idle between packets. Optional macro R_FIFO_OVERRUN_FLAG_EN adds a sticky overrun output.
module r_fifo
    import r_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic    clk,
    input  logic    resetn,
    r_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_reg, wr_ptr_next;
    logic [AW:0]       rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]  pkt_count_reg, pkt_count_next;
    logic [WIDTH-1:0]  data_out_reg, data_out_next;
    logic [WIDTH:0]    rd_entry;
    logic              do_write;
    logic              do_read;
    logic              flush;

    // Flags come straight from the pointers: equal means empty, same address on opposite laps means full
    assign bus.empty = (rd_ptr_reg == wr_ptr_reg);
    assign bus.full  = (rd_ptr_reg[AW-1:0] == wr_ptr_reg[AW-1:0]) &&
                       (rd_ptr_reg[AW] != wr_ptr_reg[AW]);

    // Any reset drops concurrent traffic, including the storage write
    assign flush    = !resetn || bus.soft_reset;
    assign do_write = bus.write_enb && !bus.full  && !flush;
    assign do_read  = bus.read_enb  && !bus.empty && !flush;

    r_fifo_mem #(
        .DEPTH (DEPTH),
        .EW    (WIDTH + 1)
    ) u_mem (
        .clk   (clk),
        .we    (do_write),
        .waddr (wr_ptr_reg[AW-1:0]),
        .wdata ({bus.lfd_state, bus.data_in}),
        .raddr (rd_ptr_reg[AW-1:0]),
        .rdata (rd_entry)
    );

    // Next pointers, read data and packet countdown
    always_comb begin
        wr_ptr_next    = wr_ptr_reg + (AW + 1)'(do_write);
        rd_ptr_next    = rd_ptr_reg + (AW + 1)'(do_read);
        pkt_count_next = pkt_count_reg;
        data_out_next  = data_out_reg;
        if (do_read) begin
            data_out_next = rd_entry[WIDTH-1:0];
            if (rd_entry[WIDTH]) begin
                pkt_count_next = pkt_len(rd_entry[LEN_MSB:0]);
            end else if (pkt_count_reg != '0) begin
                pkt_count_next = pkt_count_reg - CNT_W'(1);
            end
        end else if (pkt_count_reg == '0) begin
            data_out_next = '0;
        end
    end

    // State registers; resetn and soft_reset both return everything to the empty state
    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            pkt_count_reg <= '0;
            data_out_reg  <= '0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            pkt_count_reg <= pkt_count_next;
            data_out_reg  <= data_out_next;
        end
    end

    assign bus.data_out = data_out_reg;

`ifdef R_FIFO_OVERRUN_FLAG_EN
    logic overrun_reg;

    // Sticky error: a write refused for lack of space or a read of an empty FIFO
    always_ff @(posedge clk) begin
        if (flush) begin
            overrun_reg <= 1'b0;
        end else if ((bus.write_enb && bus.full) || (bus.read_enb && bus.empty)) begin
            overrun_reg <= 1'b1;
        end
    end

    assign bus.overrun = overrun_reg;
`endif

endmodule

// File: tb/tb_r_fifo.sv
// tb_r_fifo: directed and randomized checks of r_fifo against a queue-based reference.
module tb_r_fifo;
    import r_pkg::*;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    r_fifo_if #(.WIDTH(WIDTH)) bus ();

    r_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Reference state: stored entries in order, expected data_out, bytes left in packet
    entry_t     q[$];
    logic [7:0] m_dout;
    int         m_cnt;
    logic       m_ovr;

    int tests_run    = 0;
    int tests_failed = 0;
    bit chk_en       = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Apply one clock edge to the reference model
    task automatic model_edge(input logic rn, input logic sr, input logic we, input logic re,
                              input logic lfd, input logic [7:0] d);
        entry_t e;
        int     sz;
        sz = q.size();
        if (!rn || sr) begin
            q.delete();
            m_dout = 8'h00;
            m_cnt  = 0;
            m_ovr  = 1'b0;
        end else begin
            if ((we && sz == DEPTH) || (re && sz == 0)) m_ovr = 1'b1;
            if (re && sz > 0) begin
                e      = q.pop_front();
                m_dout = e.data;
                if (e.lfd) m_cnt = int'(e.data[7:2]) + 1;
                else if (m_cnt > 0) m_cnt = m_cnt - 1;
            end else if (m_cnt == 0) begin
                m_dout = 8'h00;
            end
            if (we && sz < DEPTH) begin
                e.lfd  = lfd;
                e.data = d;
                q.push_back(e);
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, settle just after it
    task automatic step(input logic rn, input logic sr, input logic we, input logic re,
                        input logic lfd, input logic [7:0] d);
        @(negedge clk);
        resetn         = rn;
        bus.soft_reset = sr;
        bus.write_enb  = we;
        bus.read_enb   = re;
        bus.lfd_state  = lfd;
        bus.data_in    = d;
        @(posedge clk);
        model_edge(rn, sr, we, re, lfd, d);
        #1;
    endtask

    // Every cycle: DUT outputs must match the reference
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_empty", 32'(bus.empty), 32'(q.size() == 0));
            chk("cmp_full",  32'(bus.full),  32'(q.size() == DEPTH));
            chk("cmp_dout",  32'(bus.data_out), 32'(m_dout));
`ifdef R_FIFO_OVERRUN_FLAG_EN
            chk("cmp_ovr",   32'(bus.overrun), 32'(m_ovr));
`endif
        end
    end

    logic [7:0] pkt  [5];
    logic [7:0] fill [16];
    logic       r_rn, r_sr, r_we, r_re, r_lfd;
    logic [7:0] r_d;

    initial begin
        resetn         = 1'b0;
        bus.soft_reset = 1'b0;
        bus.write_enb  = 1'b0;
        bus.read_enb   = 1'b0;
        bus.lfd_state  = 1'b0;
        bus.data_in    = 8'h00;
        q.delete();
        m_dout = 8'h00;
        m_cnt  = 0;
        m_ovr  = 1'b0;

        // Reset held for two cycles
        step(0, 0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 0, 8'h00);
        chk_en = 1'b1;
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full",  32'(bus.full),  32'd0);
        chk("rst_dout",  32'(bus.data_out), 32'h00);

        // Packet: header len 3, three payload bytes, parity
        pkt[0] = 8'h0D; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h2F;
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, (i == 0), pkt[i]);
        step(1, 0, 0, 1, 0, 8'h00);
        chk("pkt_hdr", 32'(bus.data_out), 32'h0D);
        step(1, 0, 0, 0, 0, 8'h00);
        chk("pkt_hold", 32'(bus.data_out), 32'h0D);
        for (int i = 1; i < 5; i++) begin
            step(1, 0, 0, 1, 0, 8'h00);
            chk("pkt_rd", 32'(bus.data_out), 32'(pkt[i]));
        end
        step(1, 0, 0, 0, 0, 8'h00);
        chk("pkt_idle_zero", 32'(bus.data_out), 32'h00);

        // Zero-length header: only the parity byte follows
        step(1, 0, 1, 0, 1, 8'h01);
        step(1, 0, 1, 0, 0, 8'h55);
        step(1, 0, 0, 1, 0, 8'h00);
        step(1, 0, 0, 0, 0, 8'h00);
        chk("len0_hold", 32'(bus.data_out), 32'h01);
        step(1, 0, 0, 1, 0, 8'h00);
        chk("len0_par", 32'(bus.data_out), 32'h55);
        step(1, 0, 0, 0, 0, 8'h00);
        chk("len0_zero", 32'(bus.data_out), 32'h00);

        // Fill to full, extra write dropped, drain in order
        for (int i = 0; i < 16; i++) begin
            fill[i] = 8'($urandom);
            step(1, 0, 1, 0, 0, fill[i]);
        end
        chk("fill_full", 32'(bus.full), 32'd1);
        step(1, 0, 1, 0, 0, 8'hAA);
        chk("fill_drop_full", 32'(bus.full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0, 1, 0, 8'h00);
            chk("fill_rd", 32'(bus.data_out), 32'(fill[i]));
        end
        chk("fill_empty", 32'(bus.empty), 32'd1);

        // Wrap: 15 stored, 20 cycles of concurrent read and write
        for (int i = 0; i < 15; i++) step(1, 0, 1, 0, 0, 8'(8'h80 + i));
        for (int k = 0; k < 20; k++) begin
            step(1, 0, 1, 1, 0, 8'(8'h80 + 15 + k));
            chk("wrap_rd", 32'(bus.data_out), 32'(8'(8'h80 + k)));
            chk("wrap_nfull", 32'(bus.full), 32'd0);
        end
        for (int i = 0; i < 15; i++) step(1, 0, 0, 1, 0, 8'h00);
        chk("wrap_last", 32'(bus.data_out), 32'h9C + 32'd6);
        chk("wrap_empty", 32'(bus.empty), 32'd1);

        // Soft reset with 5 stored and a concurrent write
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, 8'(8'h30 + i));
        step(1, 1, 1, 0, 0, 8'h5A);
        chk("srst_empty", 32'(bus.empty), 32'd1);
        chk("srst_dout",  32'(bus.data_out), 32'h00);
        step(1, 0, 0, 1, 0, 8'h00);
        chk("srst_absent", 32'(bus.empty), 32'd1);
        chk("srst_dout2",  32'(bus.data_out), 32'h00);
`ifdef R_FIFO_OVERRUN_FLAG_EN
        chk("ovr_set", 32'(bus.overrun), 32'd1);
        step(1, 0, 0, 0, 0, 8'h00);
        chk("ovr_sticky", 32'(bus.overrun), 32'd1);
        step(1, 1, 0, 0, 0, 8'h00);
        chk("ovr_clear", 32'(bus.overrun), 32'd0);
`endif

        // Randomized traffic including occasional headers and resets
        for (int n = 0; n < 3000; n++) begin
            r_rn  = ($urandom_range(0, 299) != 0);
            r_sr  = ($urandom_range(0, 149) == 0);
            r_we  = ($urandom_range(0, 99) < 55);
            r_re  = ($urandom_range(0, 99) < 50);
            r_lfd = ($urandom_range(0, 7) == 0);
            r_d   = 8'($urandom);
            step(r_rn, r_sr, r_we, r_re, r_lfd, r_d);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/r_fifo.md
R_FIFO -- requirements
Module: r_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of storage entries (power of two).
REQ-002 Parameter WIDTH, default 8, data byte width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 soft_reset  input  1  synchronous flush of this FIFO, driven by the synchronizer timeout.
REQ-006 write_enb  input  1  write strobe, one bit of the synchronizer's one-hot write_enb bus.
REQ-007 read_enb  input  1  read strobe from the downstream client.
REQ-008 lfd_state  input  1  marks the byte on data_in as a packet header.
REQ-009 data_in  input  WIDTH  byte to store.
REQ-010 data_out  output  WIDTH  registered read data.
REQ-011 full  output  1  no free entry.
REQ-012 empty  output  1  no stored entry; feeds synchronizer empty_N.

Function
REQ-013 Each entry SHALL hold WIDTH+1 bits: {lfd_state, data_in}.
REQ-014 Pointers SHALL be log2(DEPTH)+1 bits wide: the low bits address storage and the MSB is the wrap bit.
REQ-015 empty SHALL be 1 when rd_ptr==wr_ptr; full SHALL be 1 when the addresses are equal and the wrap bits differ; both are combinational from the pointers.
REQ-016 A write SHALL occur when write_enb=1 and full=0: store the entry at wr_ptr and increment wr_ptr. A write while full SHALL be dropped with no state change.
REQ-017 A read SHALL occur when read_enb=1 and empty=0: data_out <= stored byte, increment rd_ptr, 1-cycle latency. A read while empty SHALL be ignored.
REQ-018 A simultaneous read and write SHALL both complete in the same cycle. When full, only the read completes; when empty, only the write completes.
REQ-019 Packet counter pkt_count, 6+1 bits: a read of an entry with lfd=1 SHALL load header[7:2]+1 (payload plus parity byte).
REQ-020 A read of an entry with lfd=0 SHALL decrement pkt_count if it is nonzero. pkt_count SHALL saturate at 0.
REQ-021 With no read, data_out SHALL be driven to 0 when pkt_count==0 and SHALL otherwise hold its value.
REQ-022 A header with length field 0 SHALL load pkt_count=1, so only the parity byte follows.
REQ-023 Pointer wrap-around at DEPTH SHALL be seamless; no entry is lost or duplicated.

Reset
REQ-024 When resetn=0: wr_ptr=0, rd_ptr=0, pkt_count=0, data_out=0, empty=1, full=0. Storage contents are don't-care.
REQ-025 soft_reset=1 (with resetn=1) SHALL produce the same register values as REQ-024 on the next edge and SHALL drop any concurrent read or write.
REQ-026 Priority SHALL be resetn > soft_reset > read/write.

Configuration
REQ-027 With macro R_FIFO_OVERRUN_FLAG_EN defined, output overrun (1 bit) SHALL be added: sticky-set on a write while full or a read while empty, and cleared by resetn or soft_reset.
REQ-028 Without R_FIFO_OVERRUN_FLAG_EN, the port and its logic SHALL be absent and all other behaviour is identical.

Structure
REQ-029 Package r_pkg SHALL hold: DEPTH/WIDTH defaults, the header field positions (LEN_MSB=7, LEN_LSB=2, ADDR width 2), and the entry struct {lfd, data}.
REQ-030 Sub-module r_fifo_mem SHALL implement the storage: a 1-write/1-read synchronous array of DEPTH x (WIDTH+1) bits. Pointer, flag and counter logic stay in r_fifo.

Verification
REQ-031 Reset: after resetn low for 2 cycles -> empty=1, full=0, data_out=0x00.
REQ-032 Packet: write header 0x0D (lfd=1, len 3), then 0x11, 0x22, 0x33 and parity 0x2F, then read 5 -> data_out 0x0D, 0x11, 0x22, 0x33, 0x2F; pkt_count reaches 0 and data_out=0x00 on the next idle cycle.
REQ-033 Fill: 16 writes -> full=1. A 17th write of 0xAA is dropped; reading 16 entries returns the original order, then empty=1.
REQ-034 Wrap and concurrency: with 15 entries, simultaneous read+write for 20 cycles -> occupancy stays 15, data in order, and the pointers wrap.
REQ-035 Soft reset: with 5 entries stored and soft_reset=1 while write_enb=1 -> next cycle empty=1, data_out=0, and the written byte is absent.
REQ-036 Under R_FIFO_OVERRUN_FLAG_EN: a read with empty=1 -> overrun=1, which persists until soft_reset.
